// File: rtl/alu_ctrl_pkg.sv
// ALU control encodings, operand-B select codes and execution FSM state type.
// Shared between the ALU control decoder and the multi-cycle execution unit.
package alu_ctrl_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_CNT_W = 5;

    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111,
        CTRL_SHR = 4'b1000,
        CTRL_LUI = 4'b1001,
        CTRL_BNE = 4'b1010
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        SHAMT_SEL_REG   = 2'd0,
        SHAMT_SEL_IMM   = 2'd1,
        SHAMT_SEL_SHAMT = 2'd2,
        SHAMT_SEL_RSVD  = 2'd3
    } shamt_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic ctrl_known(input logic [3:0] ctrl);
        logic known;
        case (ctrl)
            CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB,
            CTRL_SLT, CTRL_SHR, CTRL_LUI, CTRL_BNE: known = 1'b1;
            default:                                known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result handshake bundle between decode and the multi-cycle ALU.
// master = decode/writeback side, slave = execution unit.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       ctrl_i;
    logic [1:0]       shamt_ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [15:0]      imm_i;
    logic [4:0]       shamt_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             illegal_o;

    modport master (
        output in_valid_i, ctrl_i, shamt_ctrl_i, src1_i, src2_i, imm_i, shamt_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, illegal_o
    );

    modport slave (
        input  in_valid_i, ctrl_i, shamt_ctrl_i, src1_i, src2_i, imm_i, shamt_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, illegal_o
    );
endinterface

// File: rtl/alu_sra_serial.sv
// Serial arithmetic right shifter: one bit per step, counts down a loaded amount.
// Latency: amount steps after load; last_o flags the step that brings the count to zero.
// No backpressure: steps whenever step_i is high and the count is non-zero.
module alu_sra_serial #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic [CNT_W-1:0] amount_i,
    output logic [WIDTH-1:0] step_dat_o,
    output logic             last_o
);

    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    // Value after the current step, so the parent can capture it on the last step.
    assign step_dat_o = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    assign last_o     = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= value_i;
            cnt_q <= amount_i;
        end else if (step_i && (cnt_q != '0)) begin
            acc_q <= step_dat_o;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: forms operand B, runs single-cycle ops or a serial arithmetic shift.
// Latency: 1 cycle accept->result; SHR by n>0 takes n+1 cycles (max 32).
// Backpressure: result held in DONE until out_ready_i; no accept outside IDLE.
module alu_multicycle
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_multicycle_if.slave bus
);

    alu_state_e       state;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;
    logic             out_valid_q;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res_c;
    logic             zero_c;
    logic             illegal_c;
    logic             shift_start;
    logic [WIDTH-1:0] sra_step;
    logic             sra_last;

    assign in_ready = rst_i && (state == IDLE);
    assign accept   = bus.in_valid_i && in_ready;

    always_comb begin
        opb = '0;
        case (bus.shamt_ctrl_i)
            SHAMT_SEL_REG:   opb = bus.src2_i;
            SHAMT_SEL_IMM:   opb = {{(WIDTH-16){1'b0}}, bus.imm_i};
            SHAMT_SEL_SHAMT: opb = {{(WIDTH-CNT_W){1'b0}}, bus.shamt_i};
            default:         opb = '0;
        endcase
    end

    always_comb begin
        res_c     = '0;
        zero_c    = 1'b0;
        illegal_c = (bus.shamt_ctrl_i == SHAMT_SEL_RSVD) || !ctrl_known(bus.ctrl_i);
        case (bus.ctrl_i)
            CTRL_ADD:           res_c = bus.src1_i + opb;
            CTRL_SUB, CTRL_BNE: res_c = bus.src1_i - opb;
            CTRL_AND:           res_c = bus.src1_i & opb;
            CTRL_OR:            res_c = bus.src1_i | opb;
            CTRL_SLT:           res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(opb))};
            // A zero-amount shift is the only SHR that finishes here.
            CTRL_SHR:           res_c = bus.src1_i;
            CTRL_LUI:           res_c = {opb[15:0], {(WIDTH-16){1'b0}}};
            default:            res_c = '0;
        endcase
        if (illegal_c) begin
            res_c = '0;
        end
        if (illegal_c) begin
            zero_c = 1'b0;
        end else if (bus.ctrl_i == CTRL_BNE) begin
            zero_c = (res_c != '0);
        end else begin
            zero_c = (res_c == '0);
        end
    end

    assign shift_start = accept && !illegal_c && (bus.ctrl_i == CTRL_SHR) &&
                         (opb[CNT_W-1:0] != '0);

    alu_sra_serial #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_sra (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (shift_start),
        .step_i     (state == SHIFT),
        .value_i    (bus.src1_i),
        .amount_i   (opb[CNT_W-1:0]),
        .step_dat_o (sra_step),
        .last_o     (sra_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (shift_start) begin
                        state <= SHIFT;
                    end else if (accept) begin
                        result_q    <= res_c;
                        zero_q      <= zero_c;
                        illegal_q   <= illegal_c;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                SHIFT: begin
                    if (sra_last) begin
                        result_q    <= sra_step;
                        zero_q      <= (sra_step == '0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.zero_o      = zero_q;
    assign bus.illegal_o   = illegal_q;

endmodule
